// File: rtl/branch_predictor.sv
// Dual-port branch history/target table for the fetch stage.
// Two registered lookups per cycle, one resolve-stage update port, and an init walk after reset.
module branch_predictor #(
  parameter int IDX_W = 11,
  parameter int PC_W  = 13
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  input  logic             stall,
  input  logic             upd_wen,
  input  logic [IDX_W-1:0] upd_addr,
  input  logic [15:0]      upd_data,
  output logic             pred_taken1,
  output logic [PC_W-1:0]  pred_target1,
  output logic             pred_taken2,
  output logic [PC_W-1:0]  pred_target2,
  output logic             busy
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } stateT;

  stateT state;
  stateT nextState;

  logic [IDX_W-1:0] initPtr;
  logic             ptrLast;

  logic            entryValid  [DEPTH];
  logic [1:0]      entryCtr    [DEPTH];
  logic [PC_W-1:0] entryTarget [DEPTH];

  logic             updActive;
  logic             updTaken;
  logic [PC_W-1:0]  updTarget;
  logic             curValid;
  logic [1:0]       curCtr;
  logic [PC_W-1:0]  curTarget;
  logic             newValid;
  logic [1:0]       newCtr;
  logic [PC_W-1:0]  newTarget;

  logic             tblWen;
  logic [IDX_W-1:0] tblAddr;
  logic             tblValid;
  logic [1:0]       tblCtr;
  logic [PC_W-1:0]  tblTarget;

  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  logic             hit1;
  logic             hit2;
  logic             look1Valid;
  logic [1:0]       look1Ctr;
  logic [PC_W-1:0]  look1Target;
  logic             look2Valid;
  logic [1:0]       look2Ctr;
  logic [PC_W-1:0]  look2Target;

  // Reserved update bits and PC byte offsets carry no information for the table.
  logic [5:0] unusedBits;
  assign unusedBits = {upd_data[14:13], pc1[1:0], pc2[1:0]};

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      initPtr <= '0;
    end else if (state == INIT) begin
      initPtr <= initPtr + IDX_W'(1);
    end
  end

  assign ptrLast = &initPtr;

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      INIT:    if (ptrLast) nextState = RUN;
      RUN:     nextState = RUN;
      default: nextState = INIT;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = (state == INIT);
    updActive = (state == RUN) && upd_wen && !RST;
  end

  assign updTaken  = upd_data[15];
  assign updTarget = upd_data[PC_W-1:0];
  assign curValid  = entryValid[upd_addr];
  assign curCtr    = entryCtr[upd_addr];
  assign curTarget = entryTarget[upd_addr];

  // Post-update entry value; shared by the write port and the lookup bypass.
  always_comb begin
    newValid  = 1'b1;
    newCtr    = curCtr;
    newTarget = curTarget;
    if (!curValid) begin
      newCtr    = updTaken ? 2'b10 : 2'b01;
      newTarget = updTaken ? updTarget : '0;
    end else if (updTaken) begin
      newCtr    = (curCtr == 2'b11) ? 2'b11 : curCtr + 2'd1;
      newTarget = updTarget;
    end else begin
      newCtr    = (curCtr == 2'b00) ? 2'b00 : curCtr - 2'd1;
    end
  end

  always_comb begin
    tblWen    = 1'b0;
    tblAddr   = upd_addr;
    tblValid  = newValid;
    tblCtr    = newCtr;
    tblTarget = newTarget;
    if (state == INIT && !RST) begin
      tblWen    = 1'b1;
      tblAddr   = initPtr;
      tblValid  = 1'b0;
      tblCtr    = 2'b01;
      tblTarget = '0;
    end else if (updActive) begin
      tblWen    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (tblWen) begin
      entryValid[tblAddr]  <= tblValid;
      entryCtr[tblAddr]    <= tblCtr;
      entryTarget[tblAddr] <= tblTarget;
    end
  end

  assign idx1 = pc1[IDX_W+1:2];
  assign idx2 = pc2[IDX_W+1:2];
  assign hit1 = updActive && (upd_addr == idx1);
  assign hit2 = updActive && (upd_addr == idx2);

  always_comb begin
    look1Valid  = hit1 ? newValid  : entryValid[idx1];
    look1Ctr    = hit1 ? newCtr    : entryCtr[idx1];
    look1Target = hit1 ? newTarget : entryTarget[idx1];
    look2Valid  = hit2 ? newValid  : entryValid[idx2];
    look2Ctr    = hit2 ? newCtr    : entryCtr[idx2];
    look2Target = hit2 ? newTarget : entryTarget[idx2];
  end

  always_ff @(posedge CLK) begin
    if (RST || state == INIT) begin
      pred_taken1  <= 1'b0;
      pred_target1 <= '0;
      pred_taken2  <= 1'b0;
      pred_target2 <= '0;
    end else if (!stall) begin
      pred_taken1  <= look1Valid && look1Ctr[1];
      pred_target1 <= look1Target;
      pred_taken2  <= look2Valid && look2Ctr[1];
      pred_target2 <= look2Target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: init walk length, training, saturation,
// bypass, stall hold, and resets in both RUN and mid-walk.
module tb_branch_predictor;

  logic        CLK;
  logic        RST;
  logic [12:0] pc1;
  logic [12:0] pc2;
  logic        stall;
  logic        upd_wen;
  logic [10:0] upd_addr;
  logic [15:0] upd_data;
  logic        pred_taken1;
  logic [12:0] pred_target1;
  logic        pred_taken2;
  logic [12:0] pred_target2;
  logic        busy;

  branch_predictor #(.IDX_W(11), .PC_W(13)) dut (
    .CLK(CLK), .RST(RST), .pc1(pc1), .pc2(pc2), .stall(stall),
    .upd_wen(upd_wen), .upd_addr(upd_addr), .upd_data(upd_data),
    .pred_taken1(pred_taken1), .pred_target1(pred_target1),
    .pred_taken2(pred_taken2), .pred_target2(pred_target2), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wen;
    logic [10:0] addr;
    logic [15:0] data;
    logic [12:0] p1;
    logic [12:0] p2;
    logic        stl;
    logic        t1;
    logic [12:0] g1;
    logic        t2;
    logic [12:0] g2;
  } vecT;

  typedef struct packed {
    logic        t1;
    logic [12:0] g1;
    logic        t2;
    logic [12:0] g2;
  } expT;

  vecT vecs [25];
  expT sbQ [$];
  int  checkCount = 0;
  int  passCount  = 0;

  function automatic vecT mk(logic w, logic [10:0] a, logic [15:0] d, logic [12:0] p1v,
                             logic [12:0] p2v, logic s, logic t1v, logic [12:0] g1v,
                             logic t2v, logic [12:0] g2v);
    vecT v;
    v.wen = w; v.addr = a; v.data = d; v.p1 = p1v; v.p2 = p2v; v.stl = s;
    v.t1 = t1v; v.g1 = g1v; v.t2 = t2v; v.g2 = g2v;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkPredsZero(input string tag);
    check({tag, "_taken1"}, 32'(pred_taken1), 32'd0);
    check({tag, "_target1"}, 32'(pred_target1), 32'd0);
    check({tag, "_taken2"}, 32'(pred_taken2), 32'd0);
    check({tag, "_target2"}, 32'(pred_target2), 32'd0);
  endtask

  task automatic idleInputs();
    pc1 = '0; pc2 = '0; stall = 1'b0; upd_wen = 1'b0; upd_addr = '0; upd_data = '0;
  endtask

  // Counts negedges with busy high, starting at the negedge where RST was dropped.
  task automatic walkCount(input int injectAt, input logic [10:0] injAddr,
                           input logic [15:0] injData, output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      upd_wen  = (n == injectAt);
      upd_addr = injAddr;
      upd_data = injData;
      n++;
      @(negedge CLK);
    end
    upd_wen = 1'b0;
  endtask

  task automatic runVecs(input int lo, input int hi);
    expT e;
    expT got;
    for (int i = lo; i <= hi; i++) begin
      upd_wen = vecs[i].wen; upd_addr = vecs[i].addr; upd_data = vecs[i].data;
      pc1 = vecs[i].p1; pc2 = vecs[i].p2; stall = vecs[i].stl;
      sbQ.push_back('{vecs[i].t1, vecs[i].g1, vecs[i].t2, vecs[i].g2});
      @(posedge CLK);
      @(negedge CLK);
      got = '{pred_taken1, pred_target1, pred_taken2, pred_target2};
      if (sbQ.size() == 0) begin
        check($sformatf("v%0d_queue", i), 32'd0, 32'd1);
      end else begin
        e = sbQ.pop_front();
        check($sformatf("v%0d_taken1", i), 32'(got.t1), 32'(e.t1));
        check($sformatf("v%0d_target1", i), 32'(got.g1), 32'(e.g1));
        check($sformatf("v%0d_taken2", i), 32'(got.t2), 32'(e.t2));
        check($sformatf("v%0d_target2", i), 32'(got.g2), 32'(e.g2));
      end
    end
    idleInputs();
  endtask

  initial begin
    int n;
    logic busyOk;

    //             wen  addr    data      pc1      pc2      stl t1  tgt1     t2  tgt2
    vecs[0]  = mk(0, 11'h000, 16'h0000, 13'h0040, 13'h1FFC, 0, 0, 13'h000, 0, 13'h000);
    vecs[1]  = mk(1, 11'h010, 16'h8400, 13'h0100, 13'h0000, 0, 0, 13'h000, 0, 13'h000);
    vecs[2]  = mk(0, 11'h000, 16'h0000, 13'h0040, 13'h0040, 0, 1, 13'h400, 1, 13'h400);
    vecs[3]  = mk(1, 11'h010, 16'h6123, 13'h0100, 13'h0000, 0, 0, 13'h000, 0, 13'h000);
    vecs[4]  = mk(1, 11'h010, 16'h0000, 13'h0040, 13'h0100, 0, 0, 13'h400, 0, 13'h000);
    vecs[5]  = mk(0, 11'h000, 16'h0000, 13'h0040, 13'h0040, 0, 0, 13'h400, 0, 13'h400);
    vecs[6]  = mk(1, 11'h7FF, 16'h9234, 13'h1FFC, 13'h0040, 0, 1, 13'h1234, 0, 13'h400);
    vecs[7]  = mk(1, 11'h7FF, 16'h9234, 13'h1FFC, 13'h1FFD, 0, 1, 13'h1234, 1, 13'h1234);
    vecs[8]  = mk(1, 11'h7FF, 16'h9234, 13'h0000, 13'h0000, 0, 0, 13'h000, 0, 13'h000);
    vecs[9]  = mk(1, 11'h7FF, 16'h9234, 13'h0000, 13'h0000, 0, 0, 13'h000, 0, 13'h000);
    vecs[10] = mk(1, 11'h7FF, 16'h8ABC, 13'h1FFC, 13'h0000, 0, 1, 13'hABC, 0, 13'h000);
    vecs[11] = mk(1, 11'h7FF, 16'h0000, 13'h1FFC, 13'h0000, 0, 1, 13'hABC, 0, 13'h000);
    vecs[12] = mk(1, 11'h7FF, 16'h0000, 13'h0000, 13'h1FFC, 0, 0, 13'h000, 0, 13'hABC);
    vecs[13] = mk(1, 11'h7FF, 16'h0000, 13'h1FFC, 13'h0000, 0, 0, 13'hABC, 0, 13'h000);
    vecs[14] = mk(1, 11'h7FF, 16'h0000, 13'h1FFC, 13'h0000, 0, 0, 13'hABC, 0, 13'h000);
    vecs[15] = mk(1, 11'h7FF, 16'h8ABC, 13'h1FFC, 13'h0000, 0, 0, 13'hABC, 0, 13'h000);
    vecs[16] = mk(1, 11'h7FF, 16'h8ABC, 13'h1FFC, 13'h0000, 0, 1, 13'hABC, 0, 13'h000);
    vecs[17] = mk(1, 11'h020, 16'h9F00, 13'h0080, 13'h0080, 0, 1, 13'h1F00, 1, 13'h1F00);
    vecs[18] = mk(0, 11'h000, 16'h0000, 13'h0040, 13'h0080, 0, 0, 13'h400, 1, 13'h1F00);
    vecs[19] = mk(0, 11'h000, 16'h0000, 13'h0100, 13'h0000, 1, 0, 13'h400, 1, 13'h1F00);
    vecs[20] = mk(1, 11'h040, 16'h8777, 13'h0100, 13'h0000, 1, 0, 13'h400, 1, 13'h1F00);
    vecs[21] = mk(0, 11'h000, 16'h0000, 13'h0100, 13'h0000, 1, 0, 13'h400, 1, 13'h1F00);
    vecs[22] = mk(0, 11'h000, 16'h0000, 13'h0100, 13'h0080, 0, 1, 13'h777, 1, 13'h1F00);
    // After the two resets: every trained entry and INIT-time update must be gone.
    vecs[23] = mk(0, 11'h000, 16'h0000, 13'h0080, 13'h0040, 0, 0, 13'h000, 0, 13'h000);
    vecs[24] = mk(0, 11'h000, 16'h0000, 13'h1FFC, 13'h0100, 0, 0, 13'h000, 0, 13'h000);

    idleInputs();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_busy", 32'(busy), 32'd1);
    checkPredsZero("reset");
    RST = 1'b0;
    walkCount(-1, 11'h000, 16'h0000, n);
    check("walk_len", 32'(n), 32'd2048);
    checkPredsZero("after_walk");

    runVecs(0, 22);

    // Reset during RUN, then again mid-walk at pointer 1000.
    RST = 1'b1;
    @(negedge CLK);
    check("run_reset_busy", 32'(busy), 32'd1);
    checkPredsZero("run_reset");
    RST = 1'b0;
    busyOk = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      upd_wen  = (k == 500);
      upd_addr = 11'h020;
      upd_data = 16'h9F00;
      @(negedge CLK);
    end
    upd_wen = 1'b0;
    check("partial_walk_busy", 32'(busyOk), 32'd1);
    checkPredsZero("mid_init");
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    walkCount(1500, 11'h010, 16'h8555, n);
    check("rewalk_len", 32'(n), 32'd2048);

    runVecs(23, 24);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
